// File: rtl/nor_rs_ff.sv
// Clocked model of a cross-coupled two-NOR RS latch; S/R sampled on CLK_DRV, Q/Q_N registered.
// Optional build macro NOR_RSFF_FORBIDDEN_CHK_EN adds a simulation-only forbidden-input monitor.
`timescale 1ns/1ps
module nor_rs_ff (
  input  logic CLK_DRV,
  input  logic RESET,
  input  logic S,
  input  logic R,
  output logic Q,
  output logic Q_N
);

  typedef enum logic [1:0] {
    CMD_HOLD   = 2'b00,
    CMD_RST    = 2'b01,
    CMD_SET    = 2'b10,
    CMD_FORBID = 2'b11
  } cmd_e;

  // Power-up values equal the reset state so an unreset simulation is defined.
  logic q_q   = 1'b0;
  logic qn_q  = 1'b1;
  logic mem_q = 1'b0;
  logic q_d, qn_d, mem_d;
  logic forbid_q;
  cmd_e cmd;

  assign cmd      = cmd_e'({S, R});
  assign forbid_q = ~q_q & ~qn_q;

  always_comb begin
    q_d   = q_q;
    qn_d  = qn_q;
    mem_d = mem_q;
    unique case (cmd)
      CMD_HOLD: begin
        // Both inputs released together from forbidden: settle to the stored value.
        if (forbid_q) begin
          q_d  = mem_q;
          qn_d = ~mem_q;
        end
      end
      CMD_RST: begin
        q_d   = 1'b0;
        qn_d  = 1'b1;
        mem_d = 1'b0;
      end
      CMD_SET: begin
        q_d   = 1'b1;
        qn_d  = 1'b0;
        mem_d = 1'b1;
      end
      CMD_FORBID: begin
        q_d  = 1'b0;
        qn_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_DRV) begin
    if (RESET) begin
      q_q   <= 1'b0;
      qn_q  <= 1'b1;
      mem_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      qn_q  <= qn_d;
      mem_q <= mem_d;
    end
  end

  assign Q   = q_q;
  assign Q_N = qn_q;

`ifdef NOR_RSFF_FORBIDDEN_CHK_EN
`ifndef SYNTHESIS
  logic [31:0] forbidden_cnt = 32'd0;

  always_ff @(posedge CLK_DRV) begin
    if (!RESET && S && R) begin
      forbidden_cnt <= forbidden_cnt + 32'd1;
      $display("nor_rs_ff warning: S and R both high at time %0t", $time);
    end
  end
`endif
`else
`endif

endmodule

// File: tb/tb_nor_rs_ff.sv
// Scoreboard bench for nor_rs_ff: directed vectors push expectations, a negedge monitor checks.
`timescale 1ns/1ps
module tb_nor_rs_ff;

  logic CLK_DRV = 1'b0;
  logic RESET   = 1'b0;
  logic S       = 1'b0;
  logic R       = 1'b0;
  logic Q, Q_N;

  nor_rs_ff dut (
    .CLK_DRV (CLK_DRV),
    .RESET   (RESET),
    .S       (S),
    .R       (R),
    .Q       (Q),
    .Q_N     (Q_N)
  );

  always #5 CLK_DRV = ~CLK_DRV;

  typedef struct {
    int   idx;
    logic q;
    logic qn;
    logic mq;
    logic mqn;
  } exp_t;

  typedef struct {
    logic rst;
    logic s;
    logic r;
    logic glitch;
    logic q;
    logic qn;
  } vec_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_forbid = 0;
  bit   done = 0;

  // Independent behavioural latch: previous output pair plus remembered value.
  logic m_q = 1'b0, m_qn = 1'b1, m_mem = 1'b0;

  task automatic check(input string name, input int idx, input logic act, input logic req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s vec %0d: got %b expected %b", name, idx, act, req);
  endtask

  task automatic model_step(input logic rst, input logic s, input logic r);
    if (rst) begin
      m_q = 0; m_qn = 1; m_mem = 0;
    end else if (s && r) begin
      m_q = 0; m_qn = 0;
    end else if (s) begin
      m_q = 1; m_qn = 0; m_mem = 1;
    end else if (r) begin
      m_q = 0; m_qn = 1; m_mem = 0;
    end else if (!m_q && !m_qn) begin
      m_q = m_mem; m_qn = !m_mem;
    end
  endtask

  // Monitor: outputs are stable between rising edges, so sample on the falling edge.
  always @(negedge CLK_DRV) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("Q", e.idx, Q, e.q);
      check("Q_N", e.idx, Q_N, e.qn);
      check("Q_model", e.idx, Q, e.mq);
      check("Q_N_model", e.idx, Q_N, e.mqn);
    end
  end

  vec_t vecs[$];

  task automatic add(input logic rst, input logic s, input logic r, input logic g,
                     input logic q, input logic qn);
    vec_t v;
    v.rst = rst; v.s = s; v.r = r; v.glitch = g; v.q = q; v.qn = qn;
    vecs.push_back(v);
  endtask

  initial begin
    // reset and idle
    add(1,0,0,0, 0,1); add(0,0,0,0, 0,1); add(0,0,0,0, 0,1);
    // set then hold
    add(0,1,0,0, 1,0); add(0,0,0,0, 1,0); add(0,0,0,0, 1,0);
    // reset then hold
    add(0,0,1,0, 0,1); add(0,0,0,0, 0,1); add(0,0,0,0, 0,1);
    // forbidden from Q=1, release both -> stored 1
    add(0,1,0,0, 1,0); add(0,1,1,0, 0,0); add(0,0,0,0, 1,0);
    // reset priority over set, then set resumes
    add(1,1,0,0, 0,1); add(0,1,0,0, 1,0);
    // partial releases
    add(0,1,1,0, 0,0); add(0,0,1,0, 0,1);
    add(0,1,1,0, 0,0); add(0,1,0,0, 1,0);
    // forbidden from stored 0, held for two cycles, release -> 0
    add(0,0,1,0, 0,1); add(0,1,1,0, 0,0); add(0,1,1,0, 0,0); add(0,0,0,0, 0,1);
    // reset during forbidden clears the forbidden pair
    add(0,1,0,0, 1,0); add(0,1,1,0, 0,0); add(1,1,1,0, 0,1); add(0,0,0,0, 0,1);
    // sub-cycle pulses not spanning a rising edge are ignored
    add(0,1,0,1, 0,1); add(0,1,0,0, 1,0); add(0,0,1,1, 1,0); add(0,0,0,0, 1,0);

    #1;
    check("powerup_Q", -1, Q, 1'b0);
    check("powerup_Q_N", -1, Q_N, 1'b1);

    foreach (vecs[i]) begin
      @(negedge CLK_DRV);
      RESET = vecs[i].rst; S = vecs[i].s; R = vecs[i].r;
      if (vecs[i].glitch) begin
        #2;
        S = 1'b0; R = 1'b0;
      end
      @(posedge CLK_DRV);
      if (!vecs[i].glitch) begin
        model_step(vecs[i].rst, vecs[i].s, vecs[i].r);
        if (!vecs[i].rst && vecs[i].s && vecs[i].r) n_forbid++;
      end else begin
        model_step(vecs[i].rst, 1'b0, 1'b0);
      end
      #1;
      sb.push_back('{idx: i, q: vecs[i].q, qn: vecs[i].qn, mq: m_q, mqn: m_qn});
    end

    @(negedge CLK_DRV);
    RESET = 0; S = 0; R = 0;
    // Drain bound: scoreboard must empty within a few cycles.
    repeat (4) @(negedge CLK_DRV);
    #1;
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", sb.size());

`ifdef NOR_RSFF_FORBIDDEN_CHK_EN
    n_chk++;
    if (dut.forbidden_cnt == 32'(n_forbid)) n_pass++;
    else $display("FAIL forbidden_cnt: got %0d expected %0d", dut.forbidden_cnt, n_forbid);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
